// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: the blank pattern, the
// active-low hex glyph table and the brightness on-time width helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase so they differ from 8 and 0
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Holds (2^dim_w) * scan_div without overflow before the shift
  function automatic int on_time_width(input int scan_div, input int dim_w);
    return $clog2(scan_div) + dim_w + 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Glyph table lookup
  always_comb begin
    seg_n = HEX_GLYPH[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: refresh prescaler, rotating anode select,
// frame-synchronous double-shadowed data, leading-zero suppression and PWM dimming.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DIM_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  input  logic [DIM_W-1:0]        brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int OTW = on_time_width(SCAN_DIV, DIM_W);
  localparam int DW  = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pcnt_r;
  logic [IW-1:0]         idx_r;
  logic [DW-1:0]         pend_dig_r, act_dig_r;
  logic [NUM_DIGITS-1:0] pend_dp_r, act_dp_r;
  logic [NUM_DIGITS-1:0] pend_blank_r, act_blank_r;
  logic [NUM_DIGITS-1:0] an_n_r;
  logic [6:0]            seg_n_r;
  logic                  dp_n_r;
  logic                  frame_tick_r;

  logic                  fb_s;
  logic [3:0]            nib_s;
  logic [6:0]            glyph_s;
  logic [NUM_DIGITS-1:0] supp_s;
  logic [OTW-1:0]        on_time_s;
  logic                  lit_s;
  logic [NUM_DIGITS-1:0] an_nxt_s;
  logic [6:0]            seg_nxt_s;
  logic                  dp_nxt_s;

  assign fb_s = (pcnt_r == PCNT_MAX) && (idx_r == IDX_MAX);

  // Prescaler and digit slot index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r <= {PW{1'b0}};
      idx_r  <= {IW{1'b0}};
    end else if (pcnt_r == PCNT_MAX) begin
      pcnt_r <= {PW{1'b0}};
      idx_r  <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1);
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
    end
  end

  // Pending and active shadows; a load on the boundary bypasses straight to active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig_r   <= {DW{1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blank_r <= {NUM_DIGITS{1'b0}};
      act_dig_r    <= {DW{1'b0}};
      act_dp_r     <= {NUM_DIGITS{1'b0}};
      act_blank_r  <= {NUM_DIGITS{1'b0}};
    end else begin
      if (load) begin
        pend_dig_r   <= digits_in;
        pend_dp_r    <= dp_in;
        pend_blank_r <= blank_in;
      end
      if (fb_s) begin
        act_dig_r   <= load ? digits_in : pend_dig_r;
        act_dp_r    <= load ? dp_in     : pend_dp_r;
        act_blank_r <= load ? blank_in  : pend_blank_r;
      end
    end
  end

  // Leading-zero run from the top digit; a set dp or a nonzero nibble ends it
  always_comb begin
    logic run_v;
    run_v  = lz_suppress;
    supp_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run_v && (act_dig_r[4*i +: 4] == 4'h0) && !act_dp_r[i]) begin
        supp_s[i] = 1'b1;
      end else begin
        supp_s[i] = 1'b0;
        run_v     = 1'b0;
      end
    end
  end

  assign nib_s = act_dig_r[{idx_r, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nib_s),
    .seg_n  (glyph_s)
  );

  // PWM window; pcnt 0 is always a dead slot between digits
  always_comb begin
    on_time_s = ((OTW'(brightness) + OTW'(1)) * OTW'(SCAN_DIV)) >> DIM_W;
    lit_s     = (pcnt_r != {PW{1'b0}}) && ({{(OTW-PW){1'b0}}, pcnt_r} < on_time_s);
  end

  // Next output pattern for the current slot
  always_comb begin
    an_nxt_s  = {NUM_DIGITS{1'b1}};
    seg_nxt_s = SEG_OFF;
    dp_nxt_s  = 1'b1;
    if (lit_s) begin
      an_nxt_s  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r);
      seg_nxt_s = (act_blank_r[idx_r] || supp_s[idx_r]) ? SEG_OFF : glyph_s;
      dp_nxt_s  = supp_s[idx_r] ? 1'b1 : ~act_dp_r[idx_r];
    end else begin
      an_nxt_s  = {NUM_DIGITS{1'b1}};
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = 1'b1;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_r       <= {NUM_DIGITS{1'b1}};
      seg_n_r      <= SEG_OFF;
      dp_n_r       <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      an_n_r       <= an_nxt_s;
      seg_n_r      <= seg_nxt_s;
      dp_n_r       <= dp_nxt_s;
      frame_tick_r <= fb_s;
    end
  end

  assign an_n       = an_n_r;
  assign seg_n      = seg_n_r;
  assign dp_n       = dp_n_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 8 clocks per slot, 3-bit dimming)
// against a frame-level behavioural model plus literal spot checks.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [2:0]  brightness = 3'd7;
  logic        load = 1'b0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .DIM_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .load        (load),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high gfedcba glyphs; the display is driven with their complement
  localparam logic [6:0] GLYPH_HI [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int checks = 0;
  int errors = 0;
  int kcnt = 0;
  int first_ft_k = -1;
  int first_an_k = -1;
  logic [3:0]  first_an_val = 4'hF;
  logic [23:0] shown = 24'h0;
  logic [23:0] latest = 24'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: cycle k after release -> slot k/8, pcnt k%8; a frame shows the last load before it began
  always @(posedge clk) begin
    int k, p, i, on;
    logic [15:0] d;
    logic [3:0]  dpv, bl, nib, e_an;
    logic        supp, e_dp, e_ft;
    logic [6:0]  e_seg;
    if (!rst_n) begin
      kcnt = 0; shown = 24'h0; latest = 24'h0;
      first_ft_k = -1; first_an_k = -1;
    end else begin
      k = kcnt;
      if (k % 32 == 0) shown = latest;
      d = shown[23:8]; dpv = shown[7:4]; bl = shown[3:0];
      p = k % 8;
      i = (k / 8) % 4;
      on = ((int'(brightness) + 1) * 8) >> 3;
      nib = d[4*i +: 4];
      supp = 1'b0;
      if (lz_suppress && i != 0) begin
        supp = 1'b1;
        for (int j = i; j < 4; j++)
          if (d[4*j +: 4] != 4'h0 || dpv[j]) supp = 1'b0;
      end
      e_an  = (p >= 1 && p < on) ? ~(4'b0001 << i) : 4'hF;
      e_seg = (bl[i] || supp) ? 7'h7F : ~GLYPH_HI[nib];
      e_dp  = supp ? 1'b1 : ~dpv[i];
      e_ft  = (k % 32 == 31);
      if (load) latest = {digits_in, dp_in, blank_in};
      kcnt++;
      #1;
      chk("an_n", 32'(an_n), 32'(e_an));
      chk("frame_tick", 32'(frame_tick), 32'(e_ft));
      chk("one_anode", 32'($countones(~an_n) <= 1), 32'd1);
      if (e_an != 4'hF) begin
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n", 32'(dp_n), 32'(e_dp));
      end
      if (frame_tick && first_ft_k < 0) first_ft_k = k;
      if (an_n != 4'hF && first_an_k < 0) begin
        first_an_k = k;
        first_an_val = an_n;
      end
    end
  end

  task automatic wait_k(input int n);
    int guard = 0;
    while (kcnt < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (kcnt < n) chk("wait_timeout", 32'(kcnt), 32'(n));
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    digits_in = d; dp_in = dpv; blank_in = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_an_n"}, 32'(an_n), 32'hF);
    chk({tag, "_seg_n"}, 32'(seg_n), 32'h7F);
    chk({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_pins("rst");
    @(negedge clk) rst_n = 1'b1;

    // Scan order, load landing in frame 1
    wait_k(2);  pulse_load(16'h1234, 4'h0, 4'h0);
    wait_k(34);
    chk("first_ft_k", 32'(first_ft_k), 32'd31);
    chk("first_an_k", 32'(first_an_k), 32'd1);
    chk("first_an_val", 32'(first_an_val), 32'hE);
    chk("lit_an_d0", 32'(an_n), 32'hE);
    chk("lit_seg_4", 32'(seg_n), 32'h19);

    // Two loads in frame 1; the last one shows in frame 2
    wait_k(40); pulse_load(16'hAAAA, 4'h0, 4'h0);
    wait_k(45); pulse_load(16'h5555, 4'h0, 4'h0);
    wait_k(58);
    chk("lit_an_d3", 32'(an_n), 32'h7);
    chk("lit_seg_1", 32'(seg_n), 32'h79);
    wait_k(66);
    chk("lit_seg_5", 32'(seg_n), 32'h12);

    // Load exactly on the frame boundary cycle
    wait_k(95); pulse_load(16'h9876, 4'h0, 4'h0);
    wait_k(98);
    chk("lit_seg_6", 32'(seg_n), 32'h02);

    // Leading-zero suppression
    wait_k(100); lz_suppress = 1'b1;
    wait_k(110); pulse_load(16'h0040, 4'h0, 4'h0);
    wait_k(130); chk("lz_d0", 32'(seg_n), 32'h40);
    wait_k(138); chk("lz_d1", 32'(seg_n), 32'h19);
    wait_k(146); chk("lz_d2", 32'(seg_n), 32'h7F); chk("lz_d2_dp", 32'(dp_n), 32'h1);
    wait_k(154); chk("lz_d3", 32'(seg_n), 32'h7F);
    wait_k(160); pulse_load(16'h0040, 4'b0100, 4'h0);
    wait_k(210); chk("lzdp_d2", 32'(seg_n), 32'h40); chk("lzdp_d2_dp", 32'(dp_n), 32'h0);

    // Blanking with decimal point kept
    wait_k(224); lz_suppress = 1'b0; pulse_load(16'h1234, 4'b0010, 4'b0010);
    wait_k(266); chk("blank_d1", 32'(seg_n), 32'h7F); chk("blank_d1_dp", 32'(dp_n), 32'h0);

    // Brightness extremes
    wait_k(290); brightness = 3'd0;
    wait_k(298); chk("dim0_off", 32'(an_n), 32'hF);
    wait_k(320); brightness = 3'd3;
    wait_k(323); chk("dim3_on", 32'(an_n), 32'hE);
    wait_k(325); chk("dim3_off", 32'(an_n), 32'hF);

    // Randomized traffic
    for (int c = 0; c < 900; c++) begin
      logic [15:0] d;
      for (int n = 0; n < 4; n++)
        d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      digits_in = d;
      dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 40) == 0) lz_suppress = 1'($urandom);
      if ($urandom_range(0, 30) == 0) brightness = 3'($urandom);
      load = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    load = 1'b0;

    // Asynchronous reset while a digit is lit
    brightness = 3'd7;
    lz_suppress = 1'b0;
    guard = 0;
    while (an_n == 4'hF && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("pre_reset_lit", 32'(an_n != 4'hF), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_pins("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_k(40);
    chk("re_first_ft_k", 32'(first_ft_k), 32'd31);
    chk("re_first_an_k", 32'(first_an_k), 32'd1);
    chk("re_first_an_val", 32'(first_an_val), 32'hE);
    chk("re_cleared_d0", 32'(seg_n), 32'h40);
    wait_k(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
